// File: rtl/spiflash_xip_if.sv
// rtl/spiflash_xip_if.sv - picorv32 native memory bus slice seen by the XIP controller
interface spiflash_xip_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic        sel;
  logic        ready;
  logic [31:0] rdata;

  modport master (output mem_valid, mem_addr, mem_wstrb, input sel, ready, rdata);
  modport slave  (input mem_valid, mem_addr, mem_wstrb, output sel, ready, rdata);
endinterface

// File: rtl/spiflash_xip_ctrl.sv
// rtl/spiflash_xip_ctrl.sv - execute-in-place SPI flash READ (0x03) controller, mode 0
module spiflash_xip_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          SCK_HALF    = 4,
  parameter int          CS_HIGH_MIN = 4,
  parameter int          HOLD_MAX    = 1024
) (
  input  logic           CLK100MHZ,
  input  logic           resetn,
  spiflash_xip_if.slave  bus,
  output logic           busy,
  output logic           spi_cs_n,
  output logic           spi_sck,
  output logic           spi_mosi,
  input  logic           spi_miso
);

  typedef enum logic [2:0] {IDLE, CSS, CMD, ADDR, DATA, HOLD, CSH} state_t;

  localparam logic [15:0] SCK_LAST  = 16'(SCK_HALF - 1);
  localparam logic [15:0] CSH_LAST  = 16'(CS_HIGH_MIN - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_MAX - 1);

  state_t      state;
  logic [15:0] div;
  logic [5:0]  bit_cnt;
  logic [31:0] tx;
  logic [30:0] rx;
  logic [21:0] cur_word;
  logic [21:0] next_word;
  logic [31:0] hold_cnt;
  logic        ready_q;
  logic [31:0] rdata_q;

  logic        in_win;
  logic        is_wr;
  logic        rd_req;
  logic        wr_req;
  logic        rd_match;
  logic        half_end;
  logic        bit_end;
  logic [31:0] rx_word;

  assign in_win   = (bus.mem_addr >= BASE_ADDR) && (bus.mem_addr <= 32'h00FF_FFFF);
  assign bus.sel  = bus.mem_valid && in_win;
  assign is_wr    = |bus.mem_wstrb;
  // The CPU still holds mem_valid during the ready cycle; it must not start a new transaction.
  assign rd_req   = bus.sel && !is_wr && !ready_q;
  assign wr_req   = bus.sel && is_wr && !ready_q;
  assign rd_match = bus.sel && !is_wr && (bus.mem_addr[23:2] == cur_word);
  assign half_end = (div == SCK_LAST);
  assign bit_end  = spi_sck && half_end;
  assign rx_word  = {rx, spi_miso};

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign busy      = (state != IDLE) && (state != HOLD);

  always_ff @(posedge CLK100MHZ) begin
    if (!resetn) begin
      state     <= IDLE;
      div       <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      cur_word  <= '0;
      next_word <= '0;
      hold_cnt  <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      spi_cs_n  <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      ready_q <= wr_req;

      // Bit engine: low half then high half; MOSI moves with the falling edge, MISO taken at the end of high.
      if (state == CMD || state == ADDR || state == DATA) begin
        if (half_end) begin
          div     <= '0;
          spi_sck <= !spi_sck;
        end else begin
          div <= div + 16'd1;
        end
        if (bit_end) begin
          rx       <= rx_word[30:0];
          tx       <= {tx[30:0], 1'b0};
          spi_mosi <= tx[30];
          bit_cnt  <= bit_cnt + 6'd1;
        end
      end

      case (state)
        IDLE: begin
          if (rd_req) begin
            cur_word <= bus.mem_addr[23:2];
            tx       <= {8'h03, bus.mem_addr[23:2], 2'b00};
            spi_cs_n <= 1'b0;
            div      <= '0;
            state    <= CSS;
          end
        end
        CSS: begin
          if (half_end) begin
            div      <= '0;
            bit_cnt  <= '0;
            spi_mosi <= tx[31];
            state    <= CMD;
          end else begin
            div <= div + 16'd1;
          end
        end
        CMD: begin
          if (bit_end && bit_cnt == 6'd7) state <= ADDR;
        end
        ADDR: begin
          if (bit_end && bit_cnt == 6'd31) begin
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end && bit_cnt == 6'd31) begin
            rdata_q   <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
            ready_q   <= rd_match;
            next_word <= cur_word + 22'd1;
            hold_cnt  <= '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (rd_req) begin
            if (bus.mem_addr[23:2] == next_word) begin
              cur_word <= next_word;
              tx       <= '0;
              spi_mosi <= 1'b0;
              spi_sck  <= 1'b0;
              div      <= '0;
              bit_cnt  <= '0;
              state    <= DATA;
            end else begin
              spi_cs_n <= 1'b1;
              div      <= '0;
              state    <= CSH;
            end
          end else if (wr_req) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            spi_cs_n <= 1'b1;
            div      <= '0;
            state    <= CSH;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        CSH: begin
          if (div == CSH_LAST) begin
            div   <= '0;
            state <= IDLE;
          end else begin
            div <= div + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spiflash_xip_ctrl.sv
// tb/tb_spiflash_xip_ctrl.sv - directed vector bench for spiflash_xip_ctrl with a READ-only flash model
module tb_spiflash_xip_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy, spi_cs_n, spi_sck, spi_mosi;
  logic spi_miso = 1'b0;

  spiflash_xip_if bus ();

  spiflash_xip_ctrl dut (
    .CLK100MHZ(clk), .resetn(resetn), .bus(bus), .busy(busy),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    logic        chk_hdr;
    logic [31:0] hdr;
    int          rises;
    int          csh;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [7:0] v;
    case (a)
      24'h10_0000: v = 8'h13;
      24'h10_0001: v = 8'h00;
      24'h10_0002: v = 8'h00;
      24'h10_0003: v = 8'h6F;
      default: begin
        v = a[7:0] * 8'd7;
        v = v ^ a[15:8] ^ 8'h31;
      end
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
  endfunction

  // Flash model and pin monitor, sampled mid-cycle away from the DUT's active edge.
  int          n_bits = 0;
  int          rises_tot = 0;
  int          csh_tot = 0;
  int          mosi_bad = 0;
  logic [31:0] hdr = '0;
  logic        sck_q = 1'b0;
  logic        mosi_q = 1'b0;

  always @(negedge clk) begin
    int d;
    logic [7:0] fb;
    if (spi_cs_n) begin
      n_bits = 0;
      csh_tot++;
    end else if (spi_sck && !sck_q) begin
      rises_tot++;
      if (n_bits < 32) hdr = {hdr[30:0], spi_mosi};
      n_bits++;
    end else if (!spi_sck && sck_q && n_bits >= 32) begin
      d = n_bits - 32;
      fb = flash_byte(hdr[23:0] + 24'(d / 8));
      spi_miso = fb[7 - (d % 8)];
    end
    if (spi_sck && sck_q && spi_mosi != mosi_q) mosi_bad++;
    sck_q = spi_sck;
    mosi_q = spi_mosi;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  int          lat;
  int          rises_d;
  int          csh_d;
  logic [31:0] got_rdata;

  task automatic do_access(input logic [31:0] a, input logic [3:0] ws);
    int rb, cb;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wstrb = ws;
    @(posedge clk); #1;
    lat = 1;
    rb = rises_tot;
    cb = csh_tot;
    while (!bus.ready && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    got_rdata = bus.rdata;
    @(posedge clk); #1;
    rises_d = rises_tot - rb;
    csh_d = csh_tot - cb;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
  endtask

  initial begin
    int n;
    int rdy_cnt;
    int rb;

    vecs[0] = '{32'h0010_0000, 4'h0, 517, 32'h6F00_0013,          1'b1, 32'h0310_0000, 64, 0};
    vecs[1] = '{32'h0010_0004, 4'h0, 257, exp_word(24'h10_0004),  1'b0, 32'h0,        32, 0};
    vecs[2] = '{32'h0010_0100, 4'h0, 522, exp_word(24'h10_0100),  1'b1, 32'h0310_0100, 64, 5};
    vecs[3] = '{32'h0010_0008, 4'hF, 1,   32'h0,                  1'b0, 32'h0,        0,  0};
    vecs[4] = '{32'h0010_0104, 4'h0, 257, exp_word(24'h10_0104),  1'b0, 32'h0,        32, 0};
    vecs[5] = '{32'h0010_010A, 4'h0, 257, exp_word(24'h10_0108),  1'b0, 32'h0,        32, 0};
    vecs[6] = '{32'h00FF_FFFC, 4'h0, 522, exp_word(24'hFF_FFFC),  1'b1, 32'h03FF_FFFC, 64, 5};
    vecs[7] = '{32'h0010_0000, 4'h0, 522, 32'h6F00_0013,          1'b1, 32'h0310_0000, 64, 5};

    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wstrb = 4'h0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("rst_sck", {31'd0, spi_sck}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    bus.mem_valid = 1'b1;
    bus.mem_addr = 32'h000F_FFFC; #1;
    chk("sel_below", {31'd0, bus.sel}, 32'd0);
    bus.mem_addr = 32'h0100_0000; #1;
    chk("sel_above", {31'd0, bus.sel}, 32'd0);
    bus.mem_valid = 1'b0;
    bus.mem_addr = 32'h0010_0000; #1;
    chk("sel_novalid", {31'd0, bus.sel}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].addr, vecs[i].wstrb);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      if (vecs[i].wstrb == 4'h0) chk($sformatf("v%0d_rdata", i), got_rdata, vecs[i].rdata);
      if (vecs[i].chk_hdr) chk($sformatf("v%0d_cmd_addr", i), hdr, vecs[i].hdr);
      chk($sformatf("v%0d_sck_rises", i), 32'(rises_d), 32'(vecs[i].rises));
      chk($sformatf("v%0d_cs_high", i), 32'(csh_d), 32'(vecs[i].csh));
      chk($sformatf("v%0d_ready_pulse", i), {31'd0, bus.ready}, 32'd0);
      chk($sformatf("v%0d_cs_held", i), {31'd0, spi_cs_n}, 32'd0);
    end

    // HOLD idle timeout releases CS, then CSH returns to IDLE.
    n = 0;
    while (!spi_cs_n && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_timeout_cycles", 32'(n), 32'd1023);
    chk("csh_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_cs_n", {31'd0, spi_cs_n}, 32'd1);

    // mem_valid withdrawn mid-word: word completes on SPI with no ready, then HOLD.
    @(negedge clk);
    rb = rises_tot;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0010_0200;
    rdy_cnt = 0;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk); #1;
      if (bus.ready) rdy_cnt++;
      if (c == 100) bus.mem_valid = 1'b0;
    end
    chk("drop_no_ready", 32'(rdy_cnt), 32'd0);
    chk("drop_sck_rises", 32'(rises_tot - rb), 32'd64);
    chk("drop_hold_busy", {31'd0, busy}, 32'd0);
    chk("drop_hold_cs", {31'd0, spi_cs_n}, 32'd0);
    do_access(32'h0010_0204, 4'h0);
    chk("after_drop_latency", 32'(lat), 32'd257);
    chk("after_drop_rdata", got_rdata, exp_word(24'h10_0204));

    // Reset in the middle of a DATA phase.
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0010_0300;
    repeat (300) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    bus.mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("abort_sck", {31'd0, spi_sck}, 32'd0);
    chk("abort_ready", {31'd0, bus.ready}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    do_access(32'h0010_0000, 4'h0);
    chk("post_rst_latency", 32'(lat), 32'd517);
    chk("post_rst_cmd_addr", hdr, 32'h0310_0000);
    chk("post_rst_rdata", got_rdata, 32'h6F00_0013);
    chk("post_rst_rises", 32'(rises_d), 32'd64);

    chk("mosi_stable_while_sck_high", 32'(mosi_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
